// File: rtl/mem_stage.sv
// MEM pipeline stage: latches EX results, extends load data and forwards to WB and decode.
// Optional misaligned-load detection is enabled by defining MEM_UNALIGNED_CHK_EN.
module mem_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic         ex_mem_valid,
    output logic         mem_allowin,
    input  logic [107:0] ex_mem_bus,
    input  logic [31:0]  data_sram_rdata,
    output logic         mem_wb_valid,
    input  logic         wb_allowin,
    output logic [101:0] mem_wb_bus,
    output logic [37:0]  mem_id_bus
`ifdef MEM_UNALIGNED_CHK_EN
    ,
    output logic         mem_ale
`endif
);

    logic         mem_valid;
    logic         first_cycle;
    logic         mem_ready_go;
    logic [107:0] bus_q;
    logic [31:0]  rdata_buf;

    logic         gr_we;
    logic         res_from_mem;
    logic [2:0]   mem_type;
    logic [1:0]   addr_low2;
    logic [4:0]   dest;
    logic [31:0]  pc;
    logic [31:0]  inst;
    logic [31:0]  result;

    logic [31:0]  raw_word;
    logic [7:0]   byte_sel;
    logic [15:0]  half_sel;
    logic [31:0]  load_data;
    logic [31:0]  final_result;
    logic         gr_we_eff;

    assign {gr_we, res_from_mem, mem_type, addr_low2, dest, pc, inst, result} = bus_q;

    assign mem_ready_go = 1'b1;
    assign mem_wb_valid = mem_valid & mem_ready_go;
    assign mem_allowin  = ~mem_valid | (mem_ready_go & wb_allowin);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_valid   <= 1'b0;
            first_cycle <= 1'b0;
            bus_q       <= '0;
            rdata_buf   <= '0;
        end else begin
            if (mem_allowin) begin
                mem_valid <= ex_mem_valid;
            end
            if (ex_mem_valid && mem_allowin) begin
                bus_q <= ex_mem_bus;
            end
            first_cycle <= ex_mem_valid & mem_allowin;
            // SRAM data is only valid in the first MEM cycle; keep it for stalled loads.
            if (mem_valid && first_cycle && res_from_mem) begin
                rdata_buf <= data_sram_rdata;
            end
        end
    end

    assign raw_word = first_cycle ? data_sram_rdata : rdata_buf;
    assign half_sel = addr_low2[1] ? raw_word[31:16] : raw_word[15:0];

    always_comb begin
        byte_sel = raw_word[7:0];
        unique case (addr_low2)
            2'd0: byte_sel = raw_word[7:0];
            2'd1: byte_sel = raw_word[15:8];
            2'd2: byte_sel = raw_word[23:16];
            2'd3: byte_sel = raw_word[31:24];
            default: byte_sel = raw_word[7:0];
        endcase
    end

    always_comb begin
        load_data = raw_word;
        case (mem_type[1:0])
            2'b01:   load_data = {{24{~mem_type[2] & byte_sel[7]}}, byte_sel};
            2'b10:   load_data = {{16{~mem_type[2] & half_sel[15]}}, half_sel};
            default: load_data = raw_word;
        endcase
    end

    assign final_result = res_from_mem ? load_data : result;

`ifdef MEM_UNALIGNED_CHK_EN
    logic is_half;
    logic is_word;

    assign is_half   = (mem_type[1:0] == 2'b10);
    assign is_word   = (mem_type[1:0] == 2'b00) | (mem_type[1:0] == 2'b11);
    assign mem_ale   = mem_valid & res_from_mem
                     & ((is_half & addr_low2[0]) | (is_word & (addr_low2 != 2'b00)));
    assign gr_we_eff = gr_we & ~mem_ale;
`else
    assign gr_we_eff = gr_we;
`endif

    assign mem_wb_bus = {gr_we_eff, dest, pc, inst, final_result};
    assign mem_id_bus = {mem_valid & gr_we_eff, dest, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; define MEM_UNALIGNED_CHK_EN to also
// exercise the misaligned-load flag.
module tb_mem_stage;

    logic         clk;
    logic         reset;
    logic         ex_mem_valid;
    logic         mem_allowin;
    logic [107:0] ex_mem_bus;
    logic [31:0]  data_sram_rdata;
    logic         mem_wb_valid;
    logic         wb_allowin;
    logic [101:0] mem_wb_bus;
    logic [37:0]  mem_id_bus;
`ifdef MEM_UNALIGNED_CHK_EN
    logic         mem_ale;
`endif

    int checks;
    int failures;

    mem_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ex_mem_valid    (ex_mem_valid),
        .mem_allowin     (mem_allowin),
        .ex_mem_bus      (ex_mem_bus),
        .data_sram_rdata (data_sram_rdata),
        .mem_wb_valid    (mem_wb_valid),
        .wb_allowin      (wb_allowin),
        .mem_wb_bus      (mem_wb_bus),
        .mem_id_bus      (mem_id_bus)
`ifdef MEM_UNALIGNED_CHK_EN
        ,
        .mem_ale         (mem_ale)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [107:0] mk(input logic we, input logic rfm, input logic [2:0] mt,
                                        input logic [1:0] a2, input logic [4:0] d,
                                        input logic [31:0] pc, input logic [31:0] res);
        return {we, rfm, mt, a2, d, pc, ~pc, res};
    endfunction

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ex_mem_valid = 1'b0;
        ex_mem_bus = '0;
        data_sram_rdata = '0;
        wb_allowin = 1'b1;
        cyc();
        cyc();
        checks++;
        if (mem_wb_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_wb_valid got=%b exp=0", mem_wb_valid);
        end
        checks++;
        if (mem_allowin !== 1'b1) begin
            failures++;
            $display("FAIL reset_allowin got=%b exp=1", mem_allowin);
        end
        checks++;
        if (mem_id_bus !== 38'h0) begin
            failures++;
            $display("FAIL reset_id_bus got=%h exp=0", mem_id_bus);
        end
        checks++;
        if (mem_wb_bus !== 102'h0) begin
            failures++;
            $display("FAIL reset_wb_bus got=%h exp=0", mem_wb_bus);
        end
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_lb();
        ex_mem_valid = 1'b1;
        ex_mem_bus = mk(1'b1, 1'b1, 3'b001, 2'd3, 5'd7, 32'h1c00_0010, 32'h0000_0123);
        cyc();
        ex_mem_valid = 1'b0;
        data_sram_rdata = 32'h80FF_0000;
        #1;
        checks++;
        if (mem_wb_valid !== 1'b1) begin
            failures++;
            $display("FAIL lb_wb_valid got=%b exp=1", mem_wb_valid);
        end
        checks++;
        if (mem_wb_bus[31:0] !== 32'hFFFF_FF80) begin
            failures++;
            $display("FAIL lb_result got=%h exp=ffffff80", mem_wb_bus[31:0]);
        end
        checks++;
        if (mem_wb_bus[101] !== 1'b1) begin
            failures++;
            $display("FAIL lb_gr_we got=%b exp=1", mem_wb_bus[101]);
        end
        checks++;
        if (mem_wb_bus[95:64] !== 32'h1c00_0010) begin
            failures++;
            $display("FAIL lb_pc got=%h exp=1c000010", mem_wb_bus[95:64]);
        end
        checks++;
        if (mem_id_bus !== {1'b1, 5'd7, 32'hFFFF_FF80}) begin
            failures++;
            $display("FAIL lb_id_bus got=%h exp=%h", mem_id_bus, {1'b1, 5'd7, 32'hFFFF_FF80});
        end
        cyc();
    endtask

    task automatic test_half();
        ex_mem_valid = 1'b1;
        ex_mem_bus = mk(1'b1, 1'b1, 3'b110, 2'd2, 5'd8, 32'h1c00_0020, 32'h0);
        cyc();
        ex_mem_bus = mk(1'b1, 1'b1, 3'b010, 2'd2, 5'd9, 32'h1c00_0024, 32'h0);
        data_sram_rdata = 32'h8001_1234;
        #1;
        checks++;
        if (mem_wb_bus[31:0] !== 32'h0000_8001) begin
            failures++;
            $display("FAIL lhu_result got=%h exp=00008001", mem_wb_bus[31:0]);
        end
        cyc();
        ex_mem_valid = 1'b0;
        #1;
        checks++;
        if (mem_wb_bus[31:0] !== 32'hFFFF_8001 || mem_wb_valid !== 1'b1) begin
            failures++;
            $display("FAIL lh_result got=%h v=%b exp=ffff8001 v=1", mem_wb_bus[31:0],
                     mem_wb_valid);
        end
        cyc();
    endtask

    task automatic test_stall();
        ex_mem_valid = 1'b1;
        ex_mem_bus = mk(1'b1, 1'b1, 3'b000, 2'd0, 5'd10, 32'h1c00_0030, 32'h0);
        cyc();
        ex_mem_bus = mk(1'b1, 1'b0, 3'b000, 2'd0, 5'd11, 32'h1c00_0034, 32'h0000_0055);
        data_sram_rdata = 32'hDEAD_BEEF;
        wb_allowin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (mem_allowin !== 1'b0) begin
                failures++;
                $display("FAIL stall_allowin cycle=%0d got=%b exp=0", i, mem_allowin);
            end
            checks++;
            if (mem_wb_bus[31:0] !== 32'hDEAD_BEEF || mem_wb_valid !== 1'b1) begin
                failures++;
                $display("FAIL stall_result cycle=%0d got=%h v=%b exp=deadbeef v=1", i,
                         mem_wb_bus[31:0], mem_wb_valid);
            end
            cyc();
            data_sram_rdata = 32'h0;
        end
        wb_allowin = 1'b1;
        #1;
        checks++;
        if (mem_wb_bus[31:0] !== 32'hDEAD_BEEF || mem_allowin !== 1'b1) begin
            failures++;
            $display("FAIL stall_accept got=%h allowin=%b exp=deadbeef allowin=1",
                     mem_wb_bus[31:0], mem_allowin);
        end
        cyc();
        ex_mem_valid = 1'b0;
        #1;
        checks++;
        if (mem_wb_bus[31:0] !== 32'h0000_0055 || mem_wb_bus[100:96] !== 5'd11) begin
            failures++;
            $display("FAIL stall_next got=%h dest=%0d exp=00000055 dest=11",
                     mem_wb_bus[31:0], mem_wb_bus[100:96]);
        end
        cyc();
    endtask

    task automatic test_back_to_back();
        ex_mem_valid = 1'b1;
        ex_mem_bus = mk(1'b1, 1'b0, 3'b000, 2'd0, 5'd3, 32'h1c00_0040, 32'h0000_0011);
        cyc();
        ex_mem_bus = mk(1'b1, 1'b0, 3'b000, 2'd0, 5'd4, 32'h1c00_0044, 32'h0000_0022);
        #1;
        checks++;
        if (mem_wb_valid !== 1'b1 || mem_id_bus !== {1'b1, 5'd3, 32'h11}) begin
            failures++;
            $display("FAIL b2b_first v=%b id=%h exp v=1 id=%h", mem_wb_valid, mem_id_bus,
                     {1'b1, 5'd3, 32'h11});
        end
        cyc();
        ex_mem_valid = 1'b0;
        #1;
        checks++;
        if (mem_wb_valid !== 1'b1 || mem_id_bus !== {1'b1, 5'd4, 32'h22}) begin
            failures++;
            $display("FAIL b2b_second v=%b id=%h exp v=1 id=%h", mem_wb_valid, mem_id_bus,
                     {1'b1, 5'd4, 32'h22});
        end
        cyc();
        checks++;
        if (mem_wb_valid !== 1'b0 || mem_id_bus[37] !== 1'b0 || mem_allowin !== 1'b1) begin
            failures++;
            $display("FAIL b2b_bubble v=%b bypass=%b allowin=%b exp v=0 bypass=0 allowin=1",
                     mem_wb_valid, mem_id_bus[37], mem_allowin);
        end
    endtask

    task automatic test_reset_mid_stall();
        ex_mem_valid = 1'b1;
        ex_mem_bus = mk(1'b1, 1'b1, 3'b000, 2'd0, 5'd12, 32'h1c00_0050, 32'h0);
        cyc();
        ex_mem_valid = 1'b0;
        wb_allowin = 1'b0;
        data_sram_rdata = 32'h1234_5678;
        #1;
        checks++;
        if (mem_allowin !== 1'b0 || mem_wb_valid !== 1'b1) begin
            failures++;
            $display("FAIL rst_stall_pre allowin=%b v=%b exp allowin=0 v=1", mem_allowin,
                     mem_wb_valid);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (mem_wb_valid !== 1'b0 || mem_allowin !== 1'b1 || mem_id_bus !== 38'h0) begin
            failures++;
            $display("FAIL rst_stall_async v=%b allowin=%b id=%h exp v=0 allowin=1 id=0",
                     mem_wb_valid, mem_allowin, mem_id_bus);
        end
        cyc();
        reset = 1'b0;
        wb_allowin = 1'b1;
        cyc();
        checks++;
        if (mem_wb_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_stall_post v=%b exp=0", mem_wb_valid);
        end
    endtask

`ifdef MEM_UNALIGNED_CHK_EN
    task automatic test_unaligned();
        ex_mem_valid = 1'b1;
        ex_mem_bus = mk(1'b1, 1'b1, 3'b000, 2'd1, 5'd13, 32'h1c00_0060, 32'h0);
        cyc();
        ex_mem_valid = 1'b0;
        data_sram_rdata = 32'hCAFE_F00D;
        #1;
        checks++;
        if (mem_ale !== 1'b1 || mem_wb_bus[101] !== 1'b0 || mem_id_bus[37] !== 1'b0) begin
            failures++;
            $display("FAIL ale_lw ale=%b gr_we=%b bypass=%b exp ale=1 gr_we=0 bypass=0",
                     mem_ale, mem_wb_bus[101], mem_id_bus[37]);
        end
        cyc();
    endtask
`endif

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_lb();
        test_half();
        test_stall();
        test_back_to_back();
        test_reset_mid_stall();
`ifdef MEM_UNALIGNED_CHK_EN
        test_unaligned();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: ex_mem_valid  input  1  upstream (EX) holds a valid instruction.
REQ-004 SHALL have port: mem_allowin  output  1  this stage accepts a new instruction this cycle.
REQ-005 SHALL have port: ex_mem_bus  input  108  {gr_we, res_from_mem, mem_type[2:0], addr_low2[1:0], dest[4:0], pc[31:0], inst[31:0], result[31:0]}, MSB first.
REQ-006 SHALL have port: data_sram_rdata  input  32  synchronous-SRAM read data; valid only in the cycle after EX issued the read.
REQ-007 SHALL have port: mem_wb_valid  output  1  downstream (WB) receives a valid instruction.
REQ-008 SHALL have port: wb_allowin  input  1  WB can accept this cycle.
REQ-009 SHALL have port: mem_wb_bus  output  102  {gr_we, dest[4:0], pc[31:0], inst[31:0], final_result[31:0]}.
REQ-010 SHALL have port: mem_id_bus  output  38  {mem_bypass, dest[4:0], final_result[31:0]} forwarding to decode.
REQ-011 SHALL, under MEM_UNALIGNED_CHK_EN only, have port: mem_ale  output  1  misaligned-load flag.

Function
REQ-012 SHALL keep mem_valid register; mem_ready_go = 1; mem_wb_valid = mem_valid & mem_ready_go; mem_allowin = ~mem_valid | (mem_ready_go & wb_allowin).
REQ-013 SHALL update mem_valid <= ex_mem_valid whenever mem_allowin = 1; else hold.
REQ-014 SHALL latch ex_mem_bus into bus register only when ex_mem_valid & mem_allowin; otherwise hold bus register unchanged.
REQ-015 SHALL keep first_cycle flag: set to 1 on the edge that latches a new instruction, cleared to 0 on every other edge.
REQ-016 SHALL capture data_sram_rdata into rdata_buf on the edge ending a cycle where mem_valid & first_cycle & res_from_mem; rdata_buf otherwise holds.
REQ-017 SHALL use raw_word = first_cycle ? data_sram_rdata : rdata_buf, so a load stalled by wb_allowin = 0 for any number of cycles returns the originally read data.
REQ-018 SHALL select by addr_low2: byte = raw_word[8*addr_low2 +: 8]; half = addr_low2[1] ? raw_word[31:16] : raw_word[15:0].
REQ-019 SHALL decode mem_type: [1:0]=00 word, 01 byte, 10 half, 11 treated as word; bit 2 = 1 zero-extends, 0 sign-extends (ignored for word).
REQ-020 SHALL drive final_result = res_from_mem ? extended load data : bus result (pass-through for non-loads).
REQ-021 SHALL drive mem_bypass = mem_valid & gr_we; mem_id_bus dest/final_result taken from current bus register regardless of valid.
REQ-022 SHALL be purely combinational from registers to mem_wb_bus and mem_id_bus (zero added latency; one register stage EX->MEM).
REQ-023 SHALL handle simultaneous WB accept and EX present: instruction handed to WB and new one latched on same edge, first_cycle = 1.
REQ-024 SHALL, when ex_mem_valid = 0 and mem_allowin = 1, clear mem_valid; bus register may hold stale data but mem_bypass = 0.

Reset
REQ-025 SHALL, on reset = 1 (asynchronous, any time), clear mem_valid, first_cycle, rdata_buf and bus register to 0 immediately; mem_wb_valid = 0, mem_allowin = 1, mem_id_bus = 0.
REQ-026 SHALL discard any in-flight instruction on reset mid-stall; no output to WB until a new instruction is latched after reset deasserts.

Configuration
REQ-027 SHALL, when MEM_UNALIGNED_CHK_EN is defined, assert mem_ale = mem_valid & res_from_mem & ((half & addr_low2[0]) | (word & addr_low2 != 0)), and force gr_we to 0 in mem_wb_bus and mem_bypass while mem_ale = 1.
REQ-028 SHALL, when MEM_UNALIGNED_CHK_EN is undefined, omit mem_ale and pass misaligned loads through with REQ-018 selection unchanged.

Verification
REQ-029 SHALL cover: LB, addr_low2=3, rdata=0x80FF_0000 -> final_result=0xFFFF_FF80, gr_we passed.
REQ-030 SHALL cover: LHU, addr_low2=2, rdata=0x8001_1234 -> final_result=0x0000_8001; LH same -> 0xFFFF_8001.
REQ-031 SHALL cover: LW with rdata=0xDEAD_BEEF, wb_allowin=0 for 3 cycles while rdata changes to 0x0 -> mem_allowin=0 during stall, final_result=0xDEAD_BEEF when accepted.
REQ-032 SHALL cover: back-to-back ALU instrs result 0x11, 0x22 with wb_allowin=1 -> one per cycle to WB, mem_id_bus tracks each, no bubble.
REQ-033 SHALL cover: reset asserted mid-stall -> mem_wb_valid=0 and mem_allowin=1 same cycle, before next clock edge.
REQ-034 SHALL cover (MEM_UNALIGNED_CHK_EN): LW addr_low2=1 -> mem_ale=1, mem_wb_bus gr_we=0, mem_bypass=0.
